// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory access path: access sizes, FSM states and
// big-endian lane helpers. Also imported by the CPU decoder.
package mem_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_BAD  = 2'b11;

  localparam logic [31:0] LANE_MASK_BYTE = 32'h0000_00FF;
  localparam logic [31:0] LANE_MASK_HALF = 32'h0000_FFFF;
  localparam logic [31:0] LANE_MASK_WORD = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_RESP  = 2'd3
  } mem_state_e;

  // Request fields held for the duration of one access
  typedef struct packed {
    logic        we;
    logic [1:0]  size;
    logic        is_unsigned;
    logic [1:0]  lane;
    logic [31:0] wdata;
  } mem_req_t;

  // Big-endian: byte offset 0 lives in bits [31:24]
  function automatic logic [4:0] byte_shift(input logic [1:0] off);
    return {~off, 3'b000};
  endfunction

  function automatic logic [4:0] half_shift(input logic hi);
    return {~hi, 4'b0000};
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Pipeline request/response and datamemory port bundle for mem_access_unit.
interface mem_access_unit_if #(
  parameter int unsigned WADDR_W = 11
);
  logic               req_valid;
  logic               req_ready;
  logic               req_we;
  logic [1:0]         req_size;
  logic               req_unsigned;
  logic [31:0]        req_addr;
  logic [31:0]        req_wdata;
  logic               resp_valid;
  logic [31:0]        resp_rdata;
  logic               resp_err;
  logic [WADDR_W-1:0] mem_addr;
  logic [31:0]        mem_wdata;
  logic               mem_write;
  logic               mem_read;
  logic [31:0]        mem_rdata;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
           mem_addr, mem_wdata, mem_write, mem_read
  );

  modport memory (
    input  mem_addr, mem_wdata, mem_write, mem_read,
    output mem_rdata
  );
endinterface

// File: rtl/mem_lane_align.sv
// Big-endian lane extraction with sign/zero extension for loads, and lane merge
// of store data into an existing word for sub-word stores.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  output logic [31:0] load_c,
  output logic [31:0] merge_c
);

  logic [4:0]  shift;
  logic [31:0] mask;
  logic [31:0] lane;

  always_comb begin
    shift = 5'd0;
    mask  = LANE_MASK_WORD;
    case (size)
      SIZE_BYTE: begin
        shift = byte_shift(off);
        mask  = LANE_MASK_BYTE;
      end
      SIZE_HALF: begin
        shift = half_shift(off[1]);
        mask  = LANE_MASK_HALF;
      end
      default: ;
    endcase

    lane = (word >> shift) & mask;

    case (size)
      SIZE_BYTE: load_c = is_unsigned ? lane : {{24{lane[7]}}, lane[7:0]};
      SIZE_HALF: load_c = is_unsigned ? lane : {{16{lane[15]}}, lane[15:0]};
      default:   load_c = word;
    endcase

    // Full-word mask with zero shift degenerates to plain wdata
    merge_c = (word & ~(mask << shift)) | ((wdata & mask) << shift);
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store initiator for the word-addressed datamemory: one request at a time,
// sub-word stores via read-modify-write, bad requests answered without memory access.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int unsigned WADDR_W   = 11,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input logic           clk,
  input logic           rst_n,
  mem_access_unit_if.slave bus
);

  localparam int unsigned SPAN_W = WADDR_W + 2;

  mem_state_e         state_q, state_d;
  mem_req_t           req_q, req_d;
  logic [WADDR_W-1:0] widx_q, widx_d;
  logic [31:0]        off;
  logic               bad_c;
  logic [31:0]        load_c, merge_c;

  logic               ready_d, rd_d, wr_d, rv_d, err_d;
  logic [WADDR_W-1:0] addr_d;
  logic [31:0]        wdata_d, rdata_d;

  assign off = bus.req_addr - BASE_ADDR;

  // Range check also catches addresses below BASE_ADDR through the wrap
  always_comb begin
    bad_c = (off >> SPAN_W) != 32'd0;
    case (bus.req_size)
      SIZE_HALF: bad_c = bad_c | off[0];
      SIZE_WORD: bad_c = bad_c | (off[1:0] != 2'b00);
      SIZE_BAD:  bad_c = 1'b1;
      default:   ;
    endcase
  end

  mem_lane_align u_align (
    .word        (bus.mem_rdata),
    .off         (req_q.lane),
    .size        (req_q.size),
    .is_unsigned (req_q.is_unsigned),
    .wdata       (req_q.wdata),
    .load_c      (load_c),
    .merge_c     (merge_c)
  );

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    widx_d  = widx_q;
    rdata_d = bus.resp_rdata;
    err_d   = bus.resp_err;

    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          req_d.we          = bus.req_we;
          req_d.size        = bus.req_size;
          req_d.is_unsigned = bus.req_unsigned;
          req_d.lane        = off[1:0];
          req_d.wdata       = bus.req_wdata;
          widx_d            = off[SPAN_W-1:2];
          if (bad_c) begin
            state_d = ST_RESP;
            rdata_d = 32'd0;
            err_d   = 1'b1;
          end else if (bus.req_we && (bus.req_size == SIZE_WORD)) begin
            state_d = ST_WRITE;
          end else begin
            state_d = ST_READ;
          end
        end
      end
      ST_READ: begin
        if (req_q.we) begin
          state_d = ST_WRITE;
        end else begin
          state_d = ST_RESP;
          rdata_d = load_c;
          err_d   = 1'b0;
        end
      end
      ST_WRITE: begin
        state_d = ST_RESP;
        rdata_d = 32'd0;
        err_d   = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase

    // Port outputs are registered versions of what the next state requires
    ready_d = (state_d == ST_IDLE);
    rd_d    = (state_d == ST_READ);
    wr_d    = (state_d == ST_WRITE);
    rv_d    = (state_d == ST_RESP);
    addr_d  = (rd_d || wr_d) ? widx_d : '0;
    wdata_d = 32'd0;
    if (wr_d) wdata_d = (state_q == ST_READ) ? merge_c : req_d.wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      req_q          <= '0;
      widx_q         <= '0;
      bus.req_ready  <= 1'b1;
      bus.resp_valid <= 1'b0;
      bus.resp_rdata <= 32'd0;
      bus.resp_err   <= 1'b0;
      bus.mem_addr   <= '0;
      bus.mem_wdata  <= 32'd0;
      bus.mem_write  <= 1'b0;
      bus.mem_read   <= 1'b0;
    end else begin
      state_q        <= state_d;
      req_q          <= req_d;
      widx_q         <= widx_d;
      bus.req_ready  <= ready_d;
      bus.resp_valid <= rv_d;
      bus.resp_rdata <= rdata_d;
      bus.resp_err   <= err_d;
      bus.mem_addr   <= addr_d;
      bus.mem_wdata  <= wdata_d;
      bus.mem_write  <= wr_d;
      bus.mem_read   <= rd_d;
    end
  end

endmodule
